chnl_tx_arb: RTL and testbench
==============================

# chnl_tx_arb

Round-robin scheduler that shares one `chnl_tx` input stream among `N_SRC` independent producers. The scheduler grants the stream to one source at a time and emits framed bursts: header word, up to `MAX_BURST` data words, then trailer word. Host software demultiplexes the received buffer by the header and trailer magic values. The block sits directly upstream of `chnl_tx` (its `o_*` port connects to `chnl_tx` `i_*`), with `WIDTH` equal to `chnl_tx` `TX_WIDTH`.

## Interface
Parameters:
- `N_SRC`, default 4: number of requesters, 2..256.
- `WIDTH`, default 32: word width of every stream; must be ≥32.
- `MAX_BURST`, default 16: maximum data words per grant, 1..65535.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, synchronous, active-high.
- `en_mask`  in  N_SRC  per-source enable; sampled only in IDLE.
- `i_val`  in  N_SRC  per-source valid.
- `i_rdy`  out  N_SRC  per-source ready.
- `i_data`  in  N_SRC*WIDTH  source s occupies `[s*WIDTH +: WIDTH]`.
- `o_val`  out  1  valid to `chnl_tx`.
- `o_rdy`  in  1  ready from `chnl_tx`.
- `o_data`  out  WIDTH  word to `chnl_tx`.
- `o_busy`  out  1  high in any state except IDLE.
- `o_grant`  out  $clog2(N_SRC)  currently or last granted source.

## Operation
- States: IDLE, HDR, DATA, TRL. Registers: `state`, `grant`, `rr_ptr`, `count` (16 b).
- Request vector: `req = i_val & en_mask`.
- IDLE, `|req`:
  - `grant` ← first set bit of `req` searching upward from `rr_ptr`, wrapping at `N_SRC`.
  - `count` ← 0; next state HDR.
- HDR:
  - `o_val`=1, `o_data` = header = {zeros[WIDTH-32], 8'hA5, 8'(grant), 16'h0000}.
  - On `o_rdy`, go to DATA.
- DATA:
  - `o_val` = `i_val[grant]`, `o_data` = `i_data[grant]`, `i_rdy[grant]` = `o_rdy`; all other `i_rdy` = 0.
  - On handshake, `count`+1. If the new count equals `MAX_BURST`, go to TRL.
  - If `i_val[grant]`=0 in any DATA cycle, go to TRL that cycle; no words transfer.
- TRL:
  - `o_val`=1, `o_data` = trailer = {zeros[WIDTH-32], 8'h5A, 8'(grant), 16'(count)}.
  - On `o_rdy`: `rr_ptr` ← (grant+1) mod `N_SRC`, then go to IDLE.
- Zero-length burst: the source drops `i_val` during HDR and is still low on entering DATA. The trailer then carries count 0. This is legal and must be emitted.
- `en_mask` changes outside IDLE do not affect the current burst.
- `i_rdy` is 0 in every state except DATA, and only the granted bit can be 1.
- Per-source word order is preserved. Across sources, order follows grant order.

## Timing
- Reset (synchronous, takes effect on `clk` edge with `rst`=1) sets:
  - `state`=IDLE, `grant`=0, `rr_ptr`=0, `count`=0.
  - Outputs: `o_val`=0, `i_rdy`=0, `o_data`=0, `o_busy`=0, `o_grant`=0.
- Reset mid-burst abandons the frame with no trailer. Host resynchronises on the next 0xA5 header.
- Latency: request seen in IDLE at cycle t gives the header on `o_val` at cycle t+1. The first data word can transfer at t+2 with `o_rdy` held high.
- Minimum frame overhead: 1 idle cycle + header + trailer = 3 cycles per grant.
- `o_val` in HDR/TRL holds until `o_rdy`. Header and trailer values are stable while stalled.
- In DATA, `o_val`/`o_data` pass combinationally from the granted source. `o_rdy`→`i_rdy` is combinational; there are no registers in the data path.
- Simultaneous requests in IDLE resolve strictly by round-robin from `rr_ptr`. No source waits more than `N_SRC`-1 bursts.
- `count` never exceeds `MAX_BURST`. The 16-bit trailer field holds `count` zero-extended.

## Structure
- Package `chnl_tx_arb_pkg` holds:
  - the state enum;
  - `HDR_MAGIC` = 8'hA5 and `TRL_MAGIC` = 8'h5A;
  - header/trailer field offsets (magic [31:24], src [23:16], count [15:0]).
- Sub-module `rr_pick`: combinational round-robin priority picker (`req`, `ptr` → `idx`, `found`). It is reused by future RX-side schedulers.

## Test plan
- Single source 0, 3 words 0x11,0x22,0x33 then `i_val` low, `o_rdy`=1 → `o_data` sequence A5000000, 11, 22, 33, 5A000003; `rr_ptr`=1.
- Sources 0 and 2 both continuously valid, `MAX_BURST`=16 → alternating frames src 0, 2, 0, 2, each trailer count 0x10; source 1 `i_rdy` is never 1.
- `o_rdy` toggled 1/0 every cycle during a 5-word burst from source 3 → header, trailer and data held stable while stalled; trailer 5A030005; no word lost or duplicated.
- Source 1 asserts `i_val` for one cycle only (drops during HDR) → A5010000 followed immediately by 5A010000.
- `en_mask`=4'b1011 with all sources valid → source 2 is never granted. `en_mask` cleared mid-burst → current burst completes normally.
- `rst` pulsed in DATA after 2 words → next cycle `o_val`=0, `i_rdy`=0, `o_busy`=0; the next frame starts from source 0 with a fresh header.

Source files
------------

// File: rtl/chnl_tx_arb_pkg.sv
// Shared types and frame-word layout for the chnl_tx round-robin scheduler.
// Header/trailer words carry magic, source id and word count in the low 32 bits.
package chnl_tx_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_TRL
   } state_t;

   localparam logic [7:0] HDR_MAGIC = 8'hA5;
   localparam logic [7:0] TRL_MAGIC = 8'h5A;

   localparam int MAGIC_LSB = 24;
   localparam int SRC_LSB   = 16;
   localparam int CNT_LSB   = 0;

   function automatic logic [31:0] frame_word(input logic [7:0]  magic,
                                              input logic [7:0]  src,
                                              input logic [15:0] cnt);
      logic [31:0] w;
      w = '0;
      w[MAGIC_LSB +: 8] = magic;
      w[SRC_LSB +: 8]   = src;
      w[CNT_LSB +: 16]  = cnt;
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping.
// Zero latency; no flow control.
module rr_pick #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] idx,
   output logic          found
);

   always_comb begin : pick
      int c;
      c     = 0;
      idx   = ptr;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         c = int'(ptr) + i;
         if (c >= N) c = c - N;
         if (!found && req[c[PW-1:0]]) begin
            found = 1'b1;
            idx   = PW'(c);
         end
      end
   end

endmodule

// File: rtl/chnl_tx_arb.sv
// Grants the chnl_tx stream to one source at a time as header / data burst / trailer frames.
// Header follows a request by one cycle; data and o_rdy->i_rdy pass through combinationally.
module chnl_tx_arb
   import chnl_tx_arb_pkg::*;
#(
   parameter  int N_SRC     = 4,
   parameter  int WIDTH     = 32,
   parameter  int MAX_BURST = 16,
   localparam int GW        = $clog2(N_SRC)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_SRC-1:0]       en_mask,
   input  logic [N_SRC-1:0]       i_val,
   output logic [N_SRC-1:0]       i_rdy,
   input  logic [N_SRC*WIDTH-1:0] i_data,
   output logic                   o_val,
   input  logic                   o_rdy,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_busy,
   output logic [GW-1:0]          o_grant
);

   localparam logic [15:0] BURST_LIM = 16'(MAX_BURST);

   state_t           state, state_nxt;
   logic [GW-1:0]    grant, rr_ptr, pick_idx;
   logic [15:0]      count, count_inc;
   logic [N_SRC-1:0] req;
   logic             pick_found;
   logic             src_val;
   logic [7:0]       src_id;
   logic [WIDTH-1:0] src_words [N_SRC];

   for (genvar s = 0; s < N_SRC; s++) begin : g_unpack
      assign src_words[s] = i_data[s*WIDTH +: WIDTH];
   end

   assign req       = i_val & en_mask;
   assign src_val   = i_val[grant];
   assign src_id    = 8'(grant);
   assign count_inc = count + 16'd1;
   assign o_busy    = (state != ST_IDLE);
   assign o_grant   = grant;

   rr_pick #(.N(N_SRC)) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_nxt = state;
      o_val     = 1'b0;
      o_data    = '0;
      i_rdy     = '0;
      case (state)
         ST_IDLE: begin
            if (pick_found) state_nxt = ST_HDR;
         end
         ST_HDR: begin
            o_val  = 1'b1;
            o_data = WIDTH'(frame_word(HDR_MAGIC, src_id, 16'h0000));
            if (o_rdy) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            o_val        = src_val;
            o_data       = src_words[grant];
            i_rdy[grant] = o_rdy;
            // A source going quiet closes the frame; a short or empty burst is legal.
            if (!src_val)
               state_nxt = ST_TRL;
            else if (o_rdy && count_inc == BURST_LIM)
               state_nxt = ST_TRL;
         end
         ST_TRL: begin
            o_val  = 1'b1;
            o_data = WIDTH'(frame_word(TRL_MAGIC, src_id, count));
            if (o_rdy) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         grant  <= '0;
         rr_ptr <= '0;
         count  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  grant <= pick_idx;
                  count <= '0;
               end
            end
            ST_DATA: begin
               if (src_val && o_rdy) count <= count_inc;
            end
            ST_TRL: begin
               if (o_rdy) rr_ptr <= (grant == GW'(N_SRC-1)) ? '0 : grant + GW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chnl_tx_arb.sv
// Directed bench for chnl_tx_arb: per-source word queues feed the DUT, the output stream
// is captured and compared against hand-built expected frames.
module tb_chnl_tx_arb;

   logic         clk;
   logic         rst;
   logic [3:0]   en_mask;
   logic [3:0]   i_val;
   logic [3:0]   i_rdy;
   logic [127:0] i_data;
   logic         o_val;
   logic         o_rdy;
   logic [31:0]  o_data;
   logic         o_busy;
   logic [1:0]   o_grant;

   chnl_tx_arb #(.N_SRC(4), .WIDTH(32), .MAX_BURST(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .en_mask (en_mask),
      .i_val   (i_val),
      .i_rdy   (i_rdy),
      .i_data  (i_data),
      .o_val   (o_val),
      .o_rdy   (o_rdy),
      .o_data  (o_data),
      .o_busy  (o_busy),
      .o_grant (o_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_run = 0;
   int          n_fail = 0;
   logic [31:0] mem [4][64];
   int          rd [4];
   int          wr [4];
   logic [3:0]  vgate;
   bit          tog;
   logic [31:0] cap [$];
   logic [31:0] expq [$];
   logic        prev_stall;
   logic [31:0] prev_dat;
   logic [3:0]  rdy_seen;
   int          multi_rdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wd(input int s, input int k);
      return 32'h00C0_0000 | 32'(s << 8) | 32'(k);
   endfunction

   function automatic logic [31:0] hdr(input int s);
      return {8'hA5, 8'(s), 16'h0000};
   endfunction

   function automatic logic [31:0] trl(input int s, input int n);
      return {8'h5A, 8'(s), 16'(n)};
   endfunction

   task automatic drive();
      for (int s = 0; s < 4; s++) begin
         i_val[s]          = vgate[s] && (rd[s] < wr[s]);
         i_data[s*32 +: 32] = (rd[s] < wr[s]) ? mem[s][rd[s]] : 32'h0;
      end
   endtask

   task automatic load(input int s, input int n);
      for (int k = 0; k < n; k++) begin
         mem[s][wr[s]] = wd(s, wr[s]);
         wr[s]++;
      end
   endtask

   task automatic exp_frame(input int s, input int k0, input int n);
      expq.push_back(hdr(s));
      for (int k = 0; k < n; k++) expq.push_back(wd(s, k0 + k));
      expq.push_back(trl(s, n));
   endtask

   task automatic tick();
      logic [3:0] hs;
      @(negedge clk);
      if (prev_stall) begin
         chk("stall_val", {31'b0, o_val}, 32'd1);
         chk("stall_dat", o_data, prev_dat);
      end
      prev_stall = !rst && o_val && !o_rdy;
      prev_dat   = o_data;
      if (!rst && o_val && o_rdy) cap.push_back(o_data);
      hs = rst ? 4'b0 : (i_val & i_rdy);
      rdy_seen = rdy_seen | i_rdy;
      if ($countones(i_rdy) > 1) multi_rdy++;
      if (!o_busy && i_rdy != 4'b0) multi_rdy++;
      @(posedge clk);
      #1;
      for (int s = 0; s < 4; s++) if (hs[s]) rd[s]++;
      if (tog) o_rdy = ~o_rdy;
      drive();
   endtask

   task automatic run_until(input string tag, input int n, input int budget);
      int b;
      b = 0;
      while (cap.size() < n && b < budget) begin
         tick();
         b++;
      end
      if (cap.size() < n) chk({tag, "_timeout"}, cap.size(), n);
   endtask

   task automatic cmp(input string tag);
      chk({tag, "_len"}, cap.size(), expq.size());
      for (int i = 0; i < cap.size() && i < expq.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), cap[i], expq[i]);
      cap.delete();
      expq.delete();
   endtask

   initial begin
      int b;
      rst = 1'b1; en_mask = 4'h0; o_rdy = 1'b1; vgate = 4'hF; tog = 1'b0;
      i_val = '0; i_data = '0;
      prev_stall = 1'b0; prev_dat = '0; rdy_seen = '0; multi_rdy = 0;
      for (int s = 0; s < 4; s++) begin rd[s] = 0; wr[s] = 0; end
      drive();
      tick();
      tick();
      chk("rst_o_val",   {31'b0, o_val}, 32'd0);
      chk("rst_i_rdy",   {28'b0, i_rdy}, 32'd0);
      chk("rst_o_data",  o_data, 32'd0);
      chk("rst_o_busy",  {31'b0, o_busy}, 32'd0);
      chk("rst_o_grant", {30'b0, o_grant}, 32'd0);
      rst = 1'b0;
      en_mask = 4'hF;

      // single source 0, three words
      mem[0][0] = 32'h11; mem[0][1] = 32'h22; mem[0][2] = 32'h33; wr[0] = 3;
      drive();
      run_until("s1", 5, 40);
      expq = '{32'hA500_0000, 32'h11, 32'h22, 32'h33, 32'h5A00_0003};
      cmp("s1");

      // sources 0 and 2 continuously valid: rr_ptr is now 1, so source 2 leads
      rdy_seen = '0;
      load(0, 32);
      load(2, 32);
      drive();
      run_until("s2", 72, 300);
      exp_frame(2, 0, 16);
      exp_frame(0, 3, 16);
      exp_frame(2, 16, 16);
      exp_frame(0, 19, 16);
      cmp("s2");
      chk("s2_src1_rdy", {31'b0, rdy_seen[1]}, 32'd0);
      chk("s2_grant", {30'b0, o_grant}, 32'd0);

      // source 3, five words, o_rdy toggling every cycle
      load(3, 5);
      drive();
      tog = 1'b1;
      run_until("s3", 7, 100);
      tog = 1'b0;
      o_rdy = 1'b1;
      exp_frame(3, 0, 5);
      cmp("s3");

      // source 1 valid for a single cycle: empty burst
      load(1, 1);
      drive();
      tick();
      vgate[1] = 1'b0;
      drive();
      run_until("s4", 2, 20);
      expq = '{32'hA501_0000, 32'h5A01_0000};
      cmp("s4");
      rd[1] = wr[1];
      vgate[1] = 1'b1;

      // source 2 masked; rr_ptr is 2 so order is 3, 0, 1
      rdy_seen = '0;
      en_mask = 4'b1011;
      exp_frame(3, wr[3], 4);
      exp_frame(0, wr[0], 4);
      exp_frame(1, wr[1], 4);
      load(0, 4); load(1, 4); load(2, 4); load(3, 4);
      drive();
      run_until("s5a", 18, 120);
      cmp("s5a");
      chk("s5a_src2_rdy", {31'b0, rdy_seen[2]}, 32'd0);

      // source 2 alone, mask cleared while its burst is in DATA
      en_mask = 4'b0100;
      b = 0;
      while (!o_busy && b < 10) begin tick(); b++; end
      chk("s5b_busy", {31'b0, o_busy}, 32'd1);
      tick();
      en_mask = 4'b0000;
      run_until("s5b", 6, 40);
      exp_frame(2, 32, 4);
      cmp("s5b");

      // reset in DATA after two words of a five-word burst from source 1
      en_mask = 4'hF;
      load(1, 5);
      drive();
      run_until("s6a", 3, 20);
      rst = 1'b1;
      drive();
      tick();
      chk("s6_o_val",  {31'b0, o_val}, 32'd0);
      chk("s6_i_rdy",  {28'b0, i_rdy}, 32'd0);
      chk("s6_o_busy", {31'b0, o_busy}, 32'd0);
      chk("s6_grant",  {30'b0, o_grant}, 32'd0);
      rst = 1'b0;
      cap.delete();
      exp_frame(0, wr[0], 2);
      load(0, 2);
      exp_frame(1, 7, 3);
      drive();
      run_until("s6", 9, 60);
      cmp("s6");

      chk("i_rdy_legal", 32'(multi_rdy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
